alu_flag_capture: RTL

- Consumer side of the ALU datapath.
- Accepts each ALU result (dataOut plus zero/overflow/carryout/negative flags) through a valid/ready handshake.
- Optionally latches the flags into an architectural NZCV status register, maintains a sticky overflow bit, and evaluates a 4-bit condition code for branch logic.
- Buffers results in a small FIFO toward writeback.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_cond_eval.sv | 41 ++++
 rtl/alu_flag_capture.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU status definitions: NZCV bit positions, condition codes,
// flags vector type and FIFO occupancy states.
package alu_pkg;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Status vector ordered {N,Z,C,V}, bit3..bit0.
  typedef logic [3:0] flags_t;

  // Condition codes for branch evaluation; C=1 means "no borrow" on subtract.
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // Result FIFO occupancy classes, derived from the entry count.
  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

endpackage

// File: rtl/alu_cond_eval.sv
// Purely combinational condition-code evaluator on an NZCV status vector.
// Shared with the branch unit.
module alu_cond_eval
  import alu_pkg::*;
(
  input  flags_t     flags,
  input  logic [3:0] cond,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Decode the condition code against the current flags.
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flag_capture.sv
// Consumer side of the ALU datapath: accepts results over valid/ready,
// optionally latches NZCV, keeps a sticky overflow bit, evaluates a
// condition code and buffers results toward writeback in a small FIFO.
module alu_flag_capture
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_zero,
  input  logic                     in_overflow,
  input  logic                     in_carryout,
  input  logic                     in_negative,
  input  logic                     in_set_flags,
  input  logic [3:0]               cond,
  output logic                     cond_pass,
  output logic [3:0]               flags,
  output logic                     sticky_ovf,
  input  logic                     clr_sticky,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] dataMem [DEPTH];
  flags_t            flagMem [DEPTH];

  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  occCount;
  flags_t            statusReg;
  logic              stickyReg;
  occ_e              occState;
  flags_t            inFlags;
  logic              push;
  logic              pop;

  assign inFlags[FLAG_N] = in_negative;
  assign inFlags[FLAG_Z] = in_zero;
  assign inFlags[FLAG_C] = in_carryout;
  assign inFlags[FLAG_V] = in_overflow;

  // Classify occupancy and derive the handshake; a pop frees a slot in the same cycle.
  always_comb begin
    occState = OCC_PARTIAL;
    if (occCount == '0) begin
      occState = OCC_EMPTY;
    end else if (occCount == CNT_W'(DEPTH)) begin
      occState = OCC_FULL;
    end
    out_valid = (occState != OCC_EMPTY);
    pop       = out_valid & out_ready;
    in_ready  = (occState != OCC_FULL) | pop;
    push      = in_valid & in_ready;
  end

  // Pointer and occupancy bookkeeping; reset discards everything buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      occCount <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      occCount <= occCount + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage; contents are only observable through the gated head outputs.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      dataMem[wrPtr] <= in_data;
      flagMem[wrPtr] <= inFlags;
    end
  end

  // Architectural NZCV register and sticky overflow (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      statusReg <= '0;
      stickyReg <= 1'b0;
    end else begin
      if (push && in_set_flags) begin
        statusReg <= inFlags;
      end
      if (push && in_overflow) begin
        stickyReg <= 1'b1;
      end else if (clr_sticky) begin
        stickyReg <= 1'b0;
      end
    end
  end

  // Head entry presented only while valid, zero otherwise.
  always_comb begin
    out_data  = '0;
    out_flags = '0;
    if (out_valid) begin
      out_data  = dataMem[rdPtr];
      out_flags = flagMem[rdPtr];
    end
  end

  assign flags      = statusReg;
  assign sticky_ovf = stickyReg;
  assign count      = occCount;

  alu_cond_eval condEval (
    .flags (statusReg),
    .cond  (cond),
    .pass  (cond_pass)
  );

endmodule
